// File: rtl/i2s_arb_pkg.sv
// Shared types and the per-frame source selection rule for the I2S sample arbiter.
package i2s_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        DLVR
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_S0   = 2'b01,
        SRC_S1   = 2'b10
    } src_t;

    localparam logic [1:0] MODE_AUTO = 2'b00;
    localparam logic [1:0] MODE_S0   = 2'b01;
    localparam logic [1:0] MODE_S1   = 2'b10;
    localparam logic [1:0] MODE_MUTE = 2'b11;

    typedef struct packed {
        logic take_s0;  // S0 pair is delivered
        logic take_s1;  // S1 pair is delivered
        logic drop_s0;  // S0 pair is popped and thrown away
    } pick_t;

    // Only sources with vld high are ever taken or dropped, so rdy never meets a low vld.
    function automatic pick_t pick_src(input logic [1:0] mode, input src_t owner,
                                       input logic s0_vld, input logic s1_vld);
        pick_t p;
        p = '0;
        case (mode)
            MODE_AUTO: begin
                if (owner == SRC_S0) begin
                    p.take_s0 = s0_vld;
                    p.take_s1 = !s0_vld && s1_vld;
                end else begin
                    p.take_s1 = s1_vld;
                    p.drop_s0 = s0_vld;
                end
            end
            MODE_S0: p.take_s0 = s0_vld;
            MODE_S1: p.take_s1 = s1_vld;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/i2s_smpl_arb.sv
// Per-frame stereo source arbiter with failover hysteresis, forced/mute modes and underrun count.
// Optional: define I2S_ARB_HOLD_LAST_EN to repeat the last real pair on silence frames.
module i2s_smpl_arb
    import i2s_arb_pkg::*;
#(
    parameter int LOCK_FRAMES = 4,
    parameter int MISS_LIM    = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             smpl_req,
    output logic [15:0]      smpl_lft,
    output logic [15:0]      smpl_rght,
    output logic             smpl_vld,
    input  logic             s0_vld,
    input  logic [15:0]      s0_lft,
    input  logic [15:0]      s0_rght,
    output logic             s0_rdy,
    input  logic             s1_vld,
    input  logic [15:0]      s1_lft,
    input  logic [15:0]      s1_rght,
    output logic             s1_rdy,
    input  logic [1:0]       mode,
    output logic [1:0]       active_src,
    output logic [CNT_W-1:0] undrn_cnt,
    input  logic             clr_undrn
);

    localparam int HIT_W  = $clog2(LOCK_FRAMES + 1);
    localparam int MISS_W = $clog2(MISS_LIM + 1);
    localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(LOCK_FRAMES - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIM - 1);

    state_t      state_q;
    src_t        owner_q;
    src_t        src_q;
    src_t        src_d;
    logic        smpl_vld_q;
    logic [15:0] lft_q, rght_q;
    logic [15:0] lft_d, rght_d;
    logic [15:0] fill_lft, fill_rght;

    pick_t             pick;
    logic              in_arb;
    logic              silence;
    logic              hit_inc, hit_clr, miss_inc, miss_clr;
    logic              owner_to_s0, owner_to_s1;
    logic [HIT_W-1:0]  hit_cnt;
    logic [MISS_W-1:0] miss_cnt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pick        = pick_src(mode, owner_q, s0_vld, s1_vld);
        in_arb      = (state_q == ARB);
        silence     = !pick.take_s0 && !pick.take_s1 && (mode != MODE_MUTE);
        hit_inc     = 1'b0;
        hit_clr     = 1'b0;
        miss_inc    = 1'b0;
        miss_clr    = 1'b0;
        owner_to_s0 = 1'b0;
        owner_to_s1 = 1'b0;
        if (in_arb) begin
            if (mode != MODE_AUTO) begin
                hit_clr  = 1'b1;
                miss_clr = 1'b1;
            end else if (owner_q == SRC_S0) begin
                if (s0_vld) begin
                    miss_clr = 1'b1;
                end else if (miss_cnt == MISS_LAST) begin
                    miss_clr    = 1'b1;
                    hit_clr     = 1'b1;
                    owner_to_s1 = 1'b1;
                end else begin
                    miss_inc = 1'b1;
                end
            end else begin
                if (!s0_vld) begin
                    hit_clr = 1'b1;
                end else if (hit_cnt == HIT_LAST) begin
                    hit_clr     = 1'b1;
                    owner_to_s0 = 1'b1;
                end else begin
                    hit_inc = 1'b1;
                end
            end
        end
    end

    // Pair captured at the end of ARB; mute forces zeros regardless of the hold feature.
    always_comb begin
        lft_d  = '0;
        rght_d = '0;
        src_d  = SRC_NONE;
        if (pick.take_s0) begin
            lft_d  = s0_lft;
            rght_d = s0_rght;
            src_d  = SRC_S0;
        end else if (pick.take_s1) begin
            lft_d  = s1_lft;
            rght_d = s1_rght;
            src_d  = SRC_S1;
        end else if (silence) begin
            lft_d  = fill_lft;
            rght_d = fill_rght;
        end
    end

`ifdef I2S_ARB_HOLD_LAST_EN
    logic [15:0] last_lft_q, last_rght_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_lft_q  <= '0;
            last_rght_q <= '0;
        end else if (in_arb && (pick.take_s0 || pick.take_s1)) begin
            last_lft_q  <= lft_d;
            last_rght_q <= rght_d;
        end
    end

    assign fill_lft  = last_lft_q;
    assign fill_rght = last_rght_q;
`else
    assign fill_lft  = '0;
    assign fill_rght = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= SRC_S1;
            src_q      <= SRC_NONE;
            smpl_vld_q <= 1'b0;
            lft_q      <= '0;
            rght_q     <= '0;
        end else begin
            smpl_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (smpl_req) begin
                        state_q <= ARB;
                    end
                end
                ARB: begin
                    state_q    <= DLVR;
                    smpl_vld_q <= 1'b1;
                    lft_q      <= lft_d;
                    rght_q     <= rght_d;
                    src_q      <= src_d;
                    if (owner_to_s0) begin
                        owner_q <= SRC_S0;
                    end else if (owner_to_s1) begin
                        owner_q <= SRC_S1;
                    end
                end
                DLVR: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    sat_cnt #(.W(HIT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (hit_inc),
        .clr_i (hit_clr),
        .cnt_o (hit_cnt)
    );

    sat_cnt #(.W(MISS_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (miss_inc),
        .clr_i (miss_clr),
        .cnt_o (miss_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_undrn_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (in_arb && silence),
        .clr_i (clr_undrn),
        .cnt_o (undrn_cnt)
    );

    // Pop strobes are decoded from ARB so they land one cycle after smpl_req.
    assign s0_rdy     = in_arb && (pick.take_s0 || pick.drop_s0);
    assign s1_rdy     = in_arb && pick.take_s1;
    assign smpl_vld   = smpl_vld_q;
    assign smpl_lft   = lft_q;
    assign smpl_rght  = rght_q;
    assign active_src = src_q;

endmodule

// File: tb/tb_i2s_smpl_arb.sv
// Directed bench for i2s_smpl_arb; builds with or without I2S_ARB_HOLD_LAST_EN.
module tb_i2s_smpl_arb;

    localparam int TB_CNT_W = 2;
`ifdef I2S_ARB_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                smpl_req;
    logic [15:0]         smpl_lft, smpl_rght;
    logic                smpl_vld;
    logic                s0_vld, s1_vld;
    logic [15:0]         s0_lft, s0_rght, s1_lft, s1_rght;
    logic                s0_rdy, s1_rdy;
    logic [1:0]          mode;
    logic [1:0]          active_src;
    logic [TB_CNT_W-1:0] undrn_cnt;
    logic                clr_undrn;

    int n_cmp = 0;
    int n_err = 0;

    i2s_smpl_arb #(.LOCK_FRAMES(4), .MISS_LIM(2), .CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .smpl_req   (smpl_req),
        .smpl_lft   (smpl_lft),
        .smpl_rght  (smpl_rght),
        .smpl_vld   (smpl_vld),
        .s0_vld     (s0_vld),
        .s0_lft     (s0_lft),
        .s0_rght    (s0_rght),
        .s0_rdy     (s0_rdy),
        .s1_vld     (s1_vld),
        .s1_lft     (s1_lft),
        .s1_rght    (s1_rght),
        .s1_rdy     (s1_rdy),
        .mode       (mode),
        .active_src (active_src),
        .undrn_cnt  (undrn_cnt),
        .clr_undrn  (clr_undrn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full frame: req in cycle k, rdy checked in k+1, delivered pair checked in k+2.
    task automatic run_frame(input string tag, input logic e_r0, input logic e_r1,
                             input logic [15:0] e_l, input logic [15:0] e_r,
                             input logic [1:0] e_src, input int e_und,
                             input bit chk_data, input bit clr_arb);
        smpl_req = 1'b1;
        tick();
        smpl_req  = 1'b0;
        clr_undrn = clr_arb;
        check({tag, ".s0_rdy"}, s0_rdy, e_r0);
        check({tag, ".s1_rdy"}, s1_rdy, e_r1);
        check({tag, ".vld_early"}, smpl_vld, 1'b0);
        tick();
        clr_undrn = 1'b0;
        check({tag, ".vld"}, smpl_vld, 1'b1);
        if (chk_data) begin
            check({tag, ".lft"}, smpl_lft, e_l);
            check({tag, ".rght"}, smpl_rght, e_r);
        end
        check({tag, ".src"}, active_src, e_src);
        check({tag, ".undrn"}, undrn_cnt, e_und);
        tick();
        check({tag, ".vld_end"}, smpl_vld, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; smpl_req = 1'b0; clr_undrn = 1'b0; mode = 2'b00;
        s0_vld = 1'b0; s0_lft = '0; s0_rght = '0;
        s1_vld = 1'b0; s1_lft = '0; s1_rght = '0;
        tick(); tick(); tick();
        check("rst.vld", smpl_vld, 1'b0);
        check("rst.lft", smpl_lft, 16'h0);
        check("rst.rght", smpl_rght, 16'h0);
        check("rst.src", active_src, 2'b00);
        check("rst.undrn", undrn_cnt, 0);
        check("rst.s0_rdy", s0_rdy, 1'b0);
        check("rst.s1_rdy", s1_rdy, 1'b0);
        rst_n = 1'b1;
        repeat (7) tick();

        // Owner starts as S1; S1 alone valid.
        s1_vld = 1'b1; s1_lft = 16'h1234; s1_rght = 16'hABCD;
        run_frame("t1", 1'b0, 1'b1, 16'h1234, 16'hABCD, 2'b10, 0, 1'b1, 1'b0);

        // S0 valid for four frames: popped and discarded, then ownership returns.
        s0_vld = 1'b1; s0_lft = 16'h5555; s0_rght = 16'h6666;
        for (int i = 0; i < 4; i++)
            run_frame("t2_hunt", 1'b1, 1'b1, 16'h1234, 16'hABCD, 2'b10, 0, 1'b1, 1'b0);
        run_frame("t2_lock", 1'b1, 1'b0, 16'h5555, 16'h6666, 2'b01, 0, 1'b1, 1'b0);

        // Two misses with nothing valid: silence, undrn counts, owner falls back to S1.
        s0_vld = 1'b0; s1_vld = 1'b0;
        run_frame("t3_miss1", 1'b0, 1'b0, HOLD ? 16'h5555 : 16'h0, HOLD ? 16'h6666 : 16'h0,
                  2'b00, 1, 1'b1, 1'b0);
        run_frame("t3_miss2", 1'b0, 1'b0, HOLD ? 16'h5555 : 16'h0, HOLD ? 16'h6666 : 16'h0,
                  2'b00, 2, 1'b1, 1'b0);
        s0_vld = 1'b1; s1_vld = 1'b1; s1_lft = 16'h7777; s1_rght = 16'h8888;
        run_frame("t3_failover", 1'b1, 1'b1, 16'h7777, 16'h8888, 2'b10, 2, 1'b1, 1'b0);

        // Mute: no pops, zeros, undrn untouched.
        mode = 2'b11;
        run_frame("t4_mute", 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 2, 1'b1, 1'b0);

        // Forced modes never pop the other source.
        mode = 2'b01; s0_vld = 1'b0; s1_vld = 1'b1;
        run_frame("t4_frc_s0", 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 3, 1'b0, 1'b0);
        mode = 2'b10; s0_vld = 1'b1;
        run_frame("t4_frc_s1", 1'b0, 1'b1, 16'h7777, 16'h8888, 2'b10, 3, 1'b1, 1'b0);

        // Saturation of the 2-bit undrn counter and clear-over-increment.
        mode = 2'b00; s0_vld = 1'b0; s1_vld = 1'b0;
        clr_undrn = 1'b1;
        tick();
        clr_undrn = 1'b0;
        check("t5_clr", undrn_cnt, 0);
        run_frame("t5_sil1", 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1, 1'b0, 1'b0);
        run_frame("t5_sil2", 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 2, 1'b0, 1'b0);
        run_frame("t5_sil3", 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 3, 1'b0, 1'b0);
        run_frame("t5_sil4", 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 3, 1'b0, 1'b0);
        run_frame("t5_sil5", 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 3, 1'b0, 1'b0);
        run_frame("t5_clr_inc", 1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 0, 1'b0, 1'b1);

        // Silence after a real pair: zeros by default, repeated pair with the hold feature.
        s1_vld = 1'b1; s1_lft = 16'h0100; s1_rght = 16'h0200;
        run_frame("t6_src", 1'b0, 1'b1, 16'h0100, 16'h0200, 2'b10, 0, 1'b1, 1'b0);
        s1_vld = 1'b0;
        run_frame("t6_sil", 1'b0, 1'b0, HOLD ? 16'h0100 : 16'h0, HOLD ? 16'h0200 : 16'h0,
                  2'b00, 1, 1'b1, 1'b0);

        // Reset in the ARB cycle aborts the frame.
        s1_vld = 1'b1;
        smpl_req = 1'b1;
        tick();
        smpl_req = 1'b0;
        check("t7_arb_rdy", s1_rdy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t7_rdy_abort", s1_rdy, 1'b0);
        tick();
        check("t7_vld", smpl_vld, 1'b0);
        check("t7_lft", smpl_lft, 16'h0);
        check("t7_rght", smpl_rght, 16'h0);
        check("t7_src", active_src, 2'b00);
        check("t7_undrn", undrn_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // smpl_req held through ARB and DLVR starts no second frame.
        smpl_req = 1'b1;
        tick();
        check("t8_rdy", s1_rdy, 1'b1);
        tick();
        check("t8_vld", smpl_vld, 1'b1);
        check("t8_lft", smpl_lft, 16'h0100);
        tick();
        smpl_req = 1'b0;
        check("t8_no_rdy", s1_rdy, 1'b0);
        check("t8_vld_end", smpl_vld, 1'b0);
        tick();
        check("t8_no_vld", smpl_vld, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_smpl_arb.md
Name: i2s_smpl_arb

Overview:
- Stereo sample arbiter/scheduler sitting in front of the I2S transmitter's shift register.
- Once per stereo frame, the transmitter pulses smpl_req. The block then picks a source and returns one 16-bit left/right pair.
- Source 0 is the streamed audio path (e.g. post-FIR Bluetooth data); source 1 is the local tone generator.
- Handles automatic failover with hysteresis, forced/mute modes, and underrun accounting.

Parameters:
- LOCK_FRAMES, 4, consecutive frames with s0_vld high at ARB needed before ownership returns to S0.
- MISS_LIM, 2, consecutive S0 misses while owner=S0 before ownership moves to S1.
- CNT_W, 8, width of the saturating underrun counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- smpl_req  in  1  1-clk pulse from transmitter; next stereo pair needed
- smpl_lft  out  16  left sample delivered
- smpl_rght  out  16  right sample delivered
- smpl_vld  out  1  1-clk pulse; smpl_lft/smpl_rght valid
- s0_vld  in  1  stream source has a pair available
- s0_lft  in  16  stream left
- s0_rght  in  16  stream right
- s0_rdy  out  1  1-clk pop strobe to stream source
- s1_vld, s1_lft, s1_rght, s1_rdy  same as s0_*, for the tone source
- mode  in  2  00 auto, 01 force S0, 10 force S1, 11 mute
- active_src  out  2  00 silence, 01 S0, 10 S1; source of last delivered pair
- undrn_cnt  out  CNT_W  saturating count of silence-filled frames
- clr_undrn  in  1  synchronous clear of undrn_cnt

Behaviour:
- Reset values: all outputs 0; owner=S1; hit_cnt=0; miss_cnt=0; state=IDLE; last pair=0.
- FSM states:
  - IDLE: smpl_req moves to ARB.
  - ARB (1 clk): choose source, pulse rdy on that source, move to DLVR.
  - DLVR (1 clk): register the chosen pair, pulse smpl_vld, return to IDLE.
- Latency: smpl_req high in cycle k gives s*_rdy in cycle k+1 and smpl_vld in cycle k+2.
- smpl_req arriving outside IDLE is ignored.
- Transfer occurs only when rdy & vld; rdy is never asserted to a source whose vld is low.
- Data is sampled in ARB and held in the output regs until the next DLVR.
- Auto mode, owner=S0:
  - s0_vld high: take S0, miss_cnt=0.
  - Else take S1 if s1_vld, otherwise silence; miss_cnt+1.
  - miss_cnt reaching MISS_LIM: owner=S1, miss_cnt=0, hit_cnt=0.
- Auto mode, owner=S1:
  - Take S1 if s1_vld, otherwise silence.
  - If s0_vld is high, S0 is also popped (s0_rdy) and discarded, and hit_cnt+1; otherwise hit_cnt=0.
  - hit_cnt reaching LOCK_FRAMES: owner=S0 from the next frame, hit_cnt=0.
- Force S0/S1: take that source if vld, else silence. The other source is not popped. Counters hold at 0; owner is unchanged.
- Mute: no rdy to either source; deliver zeros; active_src=00; smpl_vld still pulses; undrn_cnt unchanged.
- Mode is sampled in ARB. A change between frames takes effect at the next ARB.
- Silence in a non-mute mode: pair=0 (see Optional Feature), active_src=00, undrn_cnt+1, saturating at all-ones.
- clr_undrn in the same cycle as an increment: clear wins, undrn_cnt=0.
- Asynchronous reset mid-frame aborts the frame: no smpl_vld, no rdy; all state returns to reset values.

Optional Feature:
- Macro: I2S_ARB_HOLD_LAST_EN
- Defined: silence frames repeat the last delivered non-silent pair (reset value 0). active_src is still 00 and undrn_cnt still increments. Mute still outputs zeros.
- Undefined: silence frames output 0/0.

Decomposition:
- Package i2s_arb_pkg holds:
  - state_t enum {IDLE, ARB, DLVR}
  - src_t enum {SRC_NONE=2'b00, SRC_S0=2'b01, SRC_S1=2'b10}
  - mode constants MODE_AUTO/MODE_S0/MODE_S1/MODE_MUTE
- Sub-module sat_cnt (parameterised width, inc/clr, clear-priority, saturating) is used for hit_cnt, miss_cnt and undrn_cnt.

Test Plan:
- Reset, auto mode, s1_vld=1 with pair 0x1234/0xABCD, s0_vld=0, smpl_req at cycle 10 -> s1_rdy at 11; smpl_vld at 12 with 0x1234/0xABCD; active_src=10; undrn_cnt=0.
- Auto, s0_vld held 1 for 4 frames while owner=S1 -> S0 popped each frame and discarded; frame 5 delivers S0 data with active_src=01.
- Owner=S0, s0_vld=0 and s1_vld=0 for 2 frames -> two silence frames (0/0), undrn_cnt=2, owner=S1; frame 3 with s1_vld=1 delivers S1.
- Mode=11, both vld=1 -> no rdy pulses, 0/0 delivered, smpl_vld pulses, undrn_cnt unchanged.
- CNT_W=2, 5 silence frames -> undrn_cnt saturates at 3; clr_undrn coincident with the 6th increment -> 0.
- I2S_ARB_HOLD_LAST_EN defined: deliver S1 0x0100/0x0200, then a silence frame -> 0x0100/0x0200 repeated with active_src=00; rst_n asserted in cycle k+1 -> no smpl_vld, outputs 0.
